serial_logic_unit: RTL and testbench

- Bit-serial counterpart to the parallel 32-bit gate-level logic circuits in SimpleALU.
- Accepts two operands and an op code through a start/ready handshake, then evaluates one bit per clock, LSB first.
- Presents the 32-bit result with a valid/ack handshake.
- Used by the area-reduced ALU variant.
- The sequencer/consumer side of the logic datapath: it owns operand capture, iteration and result hand-off, which the combinational circuits do not.

---
 rtl/serial_logic_unit.sv | 112 +++++++++++
 tb/tb_serial_logic_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NOR unit: captures two operands on start, evaluates one bit
// per clock LSB first, and hands the WIDTH-bit result off through a valid/ack handshake.
//
//  state | meaning
//  IDLE  | ready for a new operation; start captures operands and op code
//  RUN   | one result bit produced per edge; WIDTH edges in total
//  DONE  | result_valid held until result_ack
module serial_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ctrl_op,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    output logic             ready,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [WIDTH-1:0] result,
    output logic             isZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] counter;
    logic             bit_val;
    logic [WIDTH-1:0] shift_next;

    always_comb begin
        bit_val = 1'b0;
        case (op_reg)
            2'b00:   bit_val = a_reg[0] & b_reg[0];
            2'b01:   bit_val = a_reg[0] | b_reg[0];
            2'b10:   bit_val = a_reg[0] ^ b_reg[0];
            default: bit_val = ~(a_reg[0] | b_reg[0]);
        endcase
        shift_next = {bit_val, shift_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            isZero       <= 1'b1;
            counter      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= 2'b00;
            shift_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= data_A;
                        b_reg     <= data_B;
                        op_reg    <= ctrl_op;
                        counter   <= '0;
                        shift_reg <= '0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    shift_reg <= shift_next;
                    counter   <= counter + 1'b1;
                    // last bit goes straight into result, not via shift_reg
                    if (counter == LAST) begin
                        result       <= shift_next;
                        isZero       <= (shift_next == '0);
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        ready        <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    ready        <= 1'b1;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Bench for serial_logic_unit: a transaction-level model checked against the DUT every
// cycle, plus directed operations with hand-computed literal results and latencies.
module tb_serial_logic_unit;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       ctrl_op = 2'b00;
    logic [WIDTH-1:0] data_A = '0;
    logic [WIDTH-1:0] data_B = '0;
    logic             ready, busy, result_valid, isZero;
    logic             result_ack = 1'b0;
    logic [WIDTH-1:0] result;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    serial_logic_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .ctrl_op(ctrl_op),
        .data_A(data_A), .data_B(data_B), .ready(ready), .busy(busy),
        .result_valid(result_valid), .result_ack(result_ack),
        .result(result), .isZero(isZero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Model: 0 idle, 1 running with m_left edges to go, 2 holding a result
    int               m_mode = 0;
    int               m_left = 0;
    logic [WIDTH-1:0] m_pending = '0;
    logic [WIDTH-1:0] m_result = '0;
    logic             m_zero = 1'b1;

    always @(posedge clock) begin
        if (reset) begin
            m_mode = 0; m_left = 0; m_result = '0; m_zero = 1'b1;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_pending = logic_op(ctrl_op, data_A, data_B);
                    m_left = WIDTH;
                    m_mode = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_result = m_pending;
                        m_zero = (m_pending == '0);
                        m_mode = 2;
                    end
                end
                default: if (result_ack) m_mode = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            check("model_ready", 32'(ready), 32'(m_mode == 0));
            check("model_busy", 32'(busy), 32'(m_mode == 1));
            check("model_valid", 32'(result_valid), 32'(m_mode == 2));
            check("model_result", result, m_result);
            check("model_zero", 32'(isZero), 32'(m_zero));
        end
    end

    task automatic begin_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        ctrl_op = op; data_A = a; data_B = b; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts edges from the accept edge until result_valid; optionally disturbs inputs.
    task automatic wait_done(input bit disturb, output int n);
        n = 0;
        while (!result_valid && n < 100) begin
            if (disturb && n < 30) begin
                start = (n % 3 == 0);
                result_ack = (n % 5 == 1);
                data_A = $urandom;
                data_B = $urandom;
                ctrl_op = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
                result_ack = 1'b0;
            end
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        start = 1'b0;
        result_ack = 1'b0;
        if (n >= 100) check("timeout_valid", 32'(n), 32'd32);
    endtask

    task automatic ack_result(input bit with_start);
        result_ack = 1'b1;
        start = with_start;
        @(posedge clock);
        @(negedge clock);
        result_ack = 1'b0;
        start = 1'b0;
        check("ready_after_ack", 32'(ready), 32'd1);
        check("busy_after_ack", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit disturb);
        int n;
        begin_op(op, a, b);
        wait_done(disturb, n);
        check({name, "_latency"}, 32'(n), 32'd32);
        check({name, "_result"}, result, exp);
        check({name, "_zero"}, 32'(isZero), 32'(exp == 32'h0));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(isZero), 32'd1);
        reset = 1'b0;
        cmp_on = 1;
        @(negedge clock);

        run_op("or", 2'b01, 32'h0000FFFF, 32'hFF000000, 32'hFF00FFFF, 0);
        repeat (10) @(negedge clock);
        check("or_hold_valid", 32'(result_valid), 32'd1);
        check("or_hold_result", result, 32'hFF00FFFF);
        ack_result(0);

        run_op("and", 2'b00, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 0);
        ack_result(0);

        run_op("xor", 2'b10, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 0);
        // start together with ack must be dropped
        ack_result(1);
        @(negedge clock);
        check("start_with_ack_ignored", 32'(ready), 32'd1);
        run_op("nor", 2'b11, 32'h0F0F0F0F, 32'h00F000F0, 32'hF000F000, 0);
        check("nor_held_in_idle_next", result, 32'hF000F000);
        ack_result(0);

        run_op("disturbed_xor", 2'b10, 32'hCAFEF00D, 32'h0000FFFF, 32'hCAFE0FF2, 1);
        ack_result(0);

        begin_op(2'b01, 32'h0000FFFF, 32'h00FF0000);
        repeat (14) @(negedge clock);
        check("mid_run_busy", 32'(busy), 32'd1);
        check("mid_run_result_held", result, 32'hCAFE0FF2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_result", result, 32'h0);
        check("midrst_zero", 32'(isZero), 32'd1);

        run_op("or_after_rst", 2'b01, 32'h00000001, 32'h00000002, 32'h00000003, 0);
        ack_result(0);

        begin_op(2'b00, 32'hFFFFFFFF, 32'h80000001);
        wait_done(0, n);
        check("and_msb_lsb_result", result, 32'h80000001);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("done_rst_valid", 32'(result_valid), 32'd0);
        check("done_rst_result", result, 32'h0);

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
